// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle MIPS control sequencer: IDLE -> DECODE -> EXEC -> (MEM) -> WB.
// Outputs decode from registered state and latched opcode; only abort (and mem_ready for the timeout pulse) act combinationally.
module mips_multicycle_ctrl #(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             instr_valid,
  input  logic [5:0]       opcode,
  output logic             instr_ready,
  input  logic             abort,
  input  logic             mem_ready,
  output logic             RegWrite,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             luiSignal,
  output logic [2:0]       alu_select,
  output logic [1:0]       mem_size,
  output logic             mem_unsigned,
  output logic [2:0]       state,
  output logic             illegal_op,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] retired
);

  localparam int WAIT_CLOG = $clog2(MEM_TIMEOUT + 1);
  localparam int WAIT_W    = (WAIT_CLOG > 1) ? WAIT_CLOG : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [5:0]        op_q, op_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [CNT_W-1:0]  retired_q, retired_d;

  logic is_load, is_store, is_alui, is_lui, is_legal;
  logic [2:0] alu_dec;

  assign is_load  = (op_q[5:3] == 3'b100) &&
                    ((op_q[2:0] == 3'b000) || (op_q[2:0] == 3'b001) || (op_q[2:0] == 3'b011) ||
                     (op_q[2:0] == 3'b100) || (op_q[2:0] == 3'b101));
  assign is_store = (op_q[5:3] == 3'b101) &&
                    ((op_q[2:0] == 3'b000) || (op_q[2:0] == 3'b001) || (op_q[2:0] == 3'b011));
  assign is_alui  = (op_q[5:3] == 3'b001) && (op_q[2:0] != 3'b111);
  assign is_lui   = (op_q == 6'b001111);
  assign is_legal = is_load | is_store | is_alui | is_lui;

  assign alu_dec[2] = op_q[1] | op_q[3];
  assign alu_dec[1] = (~op_q[1] & op_q[0]) | (op_q[3] & op_q[0]);
  assign alu_dec[0] = op_q[2] | (op_q[3] & ~op_q[0]) | (op_q[3] & op_q[1]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      op_q      <= '0;
      wait_q    <= '0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      wait_q    <= wait_d;
      retired_q <= retired_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    wait_d      = wait_q;
    retired_d   = retired_q;
    illegal_op  = 1'b0;
    mem_timeout = 1'b0;
    if (abort) begin
      state_d = S_IDLE;
      wait_d  = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (instr_valid) begin
            op_d    = opcode;
            state_d = S_DECODE;
          end
        end
        S_DECODE: begin
          if (is_legal) begin
            state_d = S_EXEC;
          end else begin
            illegal_op = 1'b1;
            state_d    = S_IDLE;
          end
        end
        S_EXEC: state_d = (is_load | is_store) ? S_MEM : S_WB;
        S_MEM: begin
          // mem_ready is checked first so a last-cycle completion is never lost to the timeout
          if (mem_ready) begin
            wait_d = '0;
            if (is_load) begin
              state_d = S_WB;
            end else begin
              retired_d = retired_q + CNT_W'(1);
              state_d   = S_IDLE;
            end
          end else if ((MEM_TIMEOUT > 0) && (wait_q == WAIT_LAST)) begin
            mem_timeout = 1'b1;
            wait_d      = '0;
            state_d     = S_IDLE;
          end else begin
            wait_d = wait_q + WAIT_W'(1);
          end
        end
        S_WB: begin
          retired_d = retired_q + CNT_W'(1);
          state_d   = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // abort also closes the fetch handshake so an opcode offered during a flush is not silently dropped
  assign instr_ready  = (state_q == S_IDLE) && !abort;
  assign RegWrite     = (state_q == S_WB) && !abort;
  assign MemRead      = (state_q == S_MEM) && is_load && !abort;
  assign MemWrite     = (state_q == S_MEM) && is_store && !abort;
  assign luiSignal    = ((state_q == S_EXEC) || (state_q == S_WB)) && is_lui;
  assign alu_select   = ((state_q == S_EXEC) || (state_q == S_MEM) || (state_q == S_WB)) ? alu_dec : 3'b000;
  assign mem_size     = (MemRead | MemWrite) ? {op_q[1], op_q[0] & ~op_q[1]} : 2'b00;
  assign mem_unsigned = MemRead & op_q[2];
  assign state        = state_q;
  assign retired      = retired_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed bench: stimulus pushes the hand-computed per-cycle output snapshot; a negedge monitor pops and compares.
module tb_mips_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       instr_valid = 1'b0;
  logic [5:0] opcode = 6'd0;
  logic       instr_ready;
  logic       abort = 1'b0;
  logic       mem_ready = 1'b0;
  logic       RegWrite, MemRead, MemWrite, luiSignal;
  logic [2:0] alu_select;
  logic [1:0] mem_size;
  logic       mem_unsigned;
  logic [2:0] state;
  logic       illegal_op, mem_timeout;
  logic [1:0] retired;

  always #5 clk = ~clk;

  mips_multicycle_ctrl #(.MEM_TIMEOUT(4), .CNT_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .opcode(opcode),
    .instr_ready(instr_ready), .abort(abort), .mem_ready(mem_ready),
    .RegWrite(RegWrite), .MemRead(MemRead), .MemWrite(MemWrite), .luiSignal(luiSignal),
    .alu_select(alu_select), .mem_size(mem_size), .mem_unsigned(mem_unsigned),
    .state(state), .illegal_op(illegal_op), .mem_timeout(mem_timeout), .retired(retired)
  );

  // {st, rdy, rw, mr, mw, lui, alu, sz, uns, ill, to, ret}
  typedef struct packed {
    logic [2:0] st;
    logic [4:0] ctl;
    logic [2:0] alu;
    logic [1:0] sz;
    logic       uns;
    logic       ill;
    logic       to;
    logic [1:0] ret;
  } obs_t;

  obs_t  exp_q[$];
  string tag_q[$];
  int    checks = 0;
  int    failures = 0;

  function automatic obs_t mk(input logic [2:0] st, input logic [4:0] ctl, input logic [2:0] alu,
                              input logic [1:0] sz, input logic uns, input logic ill,
                              input logic to, input logic [1:0] ret);
    obs_t o;
    o.st = st; o.ctl = ctl; o.alu = alu; o.sz = sz;
    o.uns = uns; o.ill = ill; o.to = to; o.ret = ret;
    return o;
  endfunction

  function automatic obs_t idle(input logic [1:0] r);
    return mk(3'd0, 5'b10000, 3'd0, 2'b00, 1'b0, 1'b0, 1'b0, r);
  endfunction

  function automatic obs_t dec(input logic [1:0] r);
    return mk(3'd1, 5'b00000, 3'd0, 2'b00, 1'b0, 1'b0, 1'b0, r);
  endfunction

  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      obs_t  e, a;
      string t;
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      a = mk(state, {instr_ready, RegWrite, MemRead, MemWrite, luiSignal}, alu_select,
             mem_size, mem_unsigned, illegal_op, mem_timeout, retired);
      checks++;
      if (a !== e) begin
        failures++;
        $display("FAIL %s: got st=%0d ctl=%b alu=%b sz=%b uns=%b ill=%b to=%b ret=%0d, expected st=%0d ctl=%b alu=%b sz=%b uns=%b ill=%b to=%b ret=%0d",
                 t, a.st, a.ctl, a.alu, a.sz, a.uns, a.ill, a.to, a.ret,
                 e.st, e.ctl, e.alu, e.sz, e.uns, e.ill, e.to, e.ret);
      end
    end
  end

  task automatic step(input string tag, input logic v, input logic [5:0] op,
                      input logic mr, input logic ab, input obs_t e);
    instr_valid = v;
    opcode      = op;
    mem_ready   = mr;
    abort       = ab;
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish within 200000 time units");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] r;
    r = 2'd0;
    @(posedge clk);
    #1;
    step("reset_state", 1'b0, 6'd0, 1'b0, 1'b0, idle(2'd0));
    rst_n = 1'b1;

    // ori: DECODE, EXEC, WB, IDLE
    step("ori_idle",   1'b1, 6'b001101, 1'b0, 1'b0, idle(r));
    step("ori_decode", 1'b0, 6'd0, 1'b0, 1'b0, dec(r));
    step("ori_exec",   1'b0, 6'd0, 1'b0, 1'b0, mk(3'd2, 5'b00000, 3'b111, 2'b00, 1'b0, 1'b0, 1'b0, r));
    step("ori_wb",     1'b0, 6'd0, 1'b0, 1'b0, mk(3'd4, 5'b01000, 3'b111, 2'b00, 1'b0, 1'b0, 1'b0, r));
    r = r + 2'd1;

    // lhu with two wait cycles
    step("lhu_idle",   1'b1, 6'b100101, 1'b0, 1'b0, idle(r));
    step("lhu_decode", 1'b0, 6'd0, 1'b0, 1'b0, dec(r));
    step("lhu_exec",   1'b0, 6'd0, 1'b0, 1'b0, mk(3'd2, 5'b00000, 3'b011, 2'b00, 1'b0, 1'b0, 1'b0, r));
    step("lhu_mem0",   1'b0, 6'd0, 1'b0, 1'b0, mk(3'd3, 5'b00100, 3'b011, 2'b01, 1'b1, 1'b0, 1'b0, r));
    step("lhu_mem1",   1'b0, 6'd0, 1'b0, 1'b0, mk(3'd3, 5'b00100, 3'b011, 2'b01, 1'b1, 1'b0, 1'b0, r));
    step("lhu_mem2",   1'b0, 6'd0, 1'b1, 1'b0, mk(3'd3, 5'b00100, 3'b011, 2'b01, 1'b1, 1'b0, 1'b0, r));
    step("lhu_wb",     1'b0, 6'd0, 1'b0, 1'b0, mk(3'd4, 5'b01000, 3'b011, 2'b00, 1'b0, 1'b0, 1'b0, r));
    r = r + 2'd1;

    // sw never acknowledged: timeout on the 4th MEM cycle, no retire
    step("swto_idle",   1'b1, 6'b101011, 1'b0, 1'b0, idle(r));
    step("swto_decode", 1'b0, 6'd0, 1'b0, 1'b0, dec(r));
    step("swto_exec",   1'b0, 6'd0, 1'b0, 1'b0, mk(3'd2, 5'b00000, 3'b111, 2'b00, 1'b0, 1'b0, 1'b0, r));
    for (int i = 0; i < 3; i++)
      step("swto_mem_wait", 1'b0, 6'd0, 1'b0, 1'b0, mk(3'd3, 5'b00010, 3'b111, 2'b10, 1'b0, 1'b0, 1'b0, r));
    step("swto_mem_last", 1'b0, 6'd0, 1'b0, 1'b0, mk(3'd3, 5'b00010, 3'b111, 2'b10, 1'b0, 1'b0, 1'b1, r));

    // sw acknowledged on the last allowed cycle: ready beats timeout
    step("sw_idle",   1'b1, 6'b101011, 1'b0, 1'b0, idle(r));
    step("sw_decode", 1'b0, 6'd0, 1'b0, 1'b0, dec(r));
    step("sw_exec",   1'b0, 6'd0, 1'b0, 1'b0, mk(3'd2, 5'b00000, 3'b111, 2'b00, 1'b0, 1'b0, 1'b0, r));
    for (int i = 0; i < 3; i++)
      step("sw_mem_wait", 1'b0, 6'd0, 1'b0, 1'b0, mk(3'd3, 5'b00010, 3'b111, 2'b10, 1'b0, 1'b0, 1'b0, r));
    step("sw_mem_ready", 1'b0, 6'd0, 1'b1, 1'b0, mk(3'd3, 5'b00010, 3'b111, 2'b10, 1'b0, 1'b0, 1'b0, r));
    r = r + 2'd1;

    // unsupported opcode
    step("ill_idle",   1'b1, 6'b000010, 1'b0, 1'b0, idle(r));
    step("ill_decode", 1'b0, 6'd0, 1'b0, 1'b0, mk(3'd1, 5'b00000, 3'd0, 2'b00, 1'b0, 1'b1, 1'b0, r));

    // lw stalled in MEM, then asynchronous reset
    step("lw_idle",   1'b1, 6'b100011, 1'b0, 1'b0, idle(r));
    step("lw_decode", 1'b0, 6'd0, 1'b0, 1'b0, dec(r));
    step("lw_exec",   1'b0, 6'd0, 1'b0, 1'b0, mk(3'd2, 5'b00000, 3'b100, 2'b00, 1'b0, 1'b0, 1'b0, r));
    for (int i = 0; i < 3; i++)
      step("lw_mem_wait", 1'b0, 6'd0, 1'b0, 1'b0, mk(3'd3, 5'b00100, 3'b100, 2'b10, 1'b0, 1'b0, 1'b0, r));
    rst_n = 1'b0;
    r = 2'd0;
    step("rst_mid_mem", 1'b0, 6'd0, 1'b0, 1'b0, idle(r));
    step("rst_hold",    1'b1, 6'b001111, 1'b0, 1'b0, idle(r));
    rst_n = 1'b1;

    // five lui back-to-back; retired wraps; busy-time opcodes must be ignored
    for (int i = 0; i < 5; i++) begin
      step("lui_idle",   1'b1, 6'b001111, 1'b0, 1'b0, idle(r));
      step("lui_decode", 1'b1, 6'b111111, 1'b0, 1'b0, dec(r));
      step("lui_exec",   1'b1, 6'b111111, 1'b0, 1'b0, mk(3'd2, 5'b00001, 3'b111, 2'b00, 1'b0, 1'b0, 1'b0, r));
      step("lui_wb",     1'b1, 6'b111111, 1'b0, 1'b0, mk(3'd4, 5'b01001, 3'b111, 2'b00, 1'b0, 1'b0, 1'b0, r));
      r = r + 2'd1;
    end

    // abort in WB: no RegWrite, no retire
    step("abwb_idle",   1'b1, 6'b001111, 1'b0, 1'b0, idle(r));
    step("abwb_decode", 1'b0, 6'd0, 1'b0, 1'b0, dec(r));
    step("abwb_exec",   1'b0, 6'd0, 1'b0, 1'b0, mk(3'd2, 5'b00001, 3'b111, 2'b00, 1'b0, 1'b0, 1'b0, r));
    step("abwb_wb",     1'b0, 6'd0, 1'b0, 1'b1, mk(3'd4, 5'b00001, 3'b111, 2'b00, 1'b0, 1'b0, 1'b0, r));

    // abort in MEM beats mem_ready: MemRead forced low, no retire
    step("abmem_idle",   1'b1, 6'b100000, 1'b0, 1'b0, idle(r));
    step("abmem_decode", 1'b0, 6'd0, 1'b0, 1'b0, dec(r));
    step("abmem_exec",   1'b0, 6'd0, 1'b0, 1'b0, mk(3'd2, 5'b00000, 3'b000, 2'b00, 1'b0, 1'b0, 1'b0, r));
    step("abmem_mem",    1'b0, 6'd0, 1'b1, 1'b1, mk(3'd3, 5'b00000, 3'b000, 2'b00, 1'b0, 1'b0, 1'b0, r));
    step("abmem_after",  1'b0, 6'd0, 1'b0, 1'b0, idle(r));

    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mips_multicycle_ctrl.md
Name: mips_multicycle_ctrl

Overview:
Multi-cycle control sequencer for the 32-bit MIPS datapath, and the successor to the single-cycle opcode decoder. It accepts one opcode per instruction from fetch over a valid/ready handshake and steps it through DECODE, EXEC, MEM and WB. It drives the RegWrite, MemRead, MemWrite, lui and 3-bit ALU select signals per state, waits on a memory ready handshake with a timeout, and counts retired instructions.

Parameters:
MEM_TIMEOUT, 15, maximum number of MEM cycles spent waiting for mem_ready; 0 disables the timeout (wait forever).
CNT_W, 16, width of the retired-instruction counter.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
instr_valid  input  1  fetch presents an opcode.
opcode  input  6  instruction opcode, bits [31:26].
instr_ready  output  1  controller can accept an opcode.
abort  input  1  synchronous flush to IDLE.
mem_ready  input  1  memory completes the current access.
RegWrite  output  1  register-file write strobe.
MemRead  output  1  memory read request.
MemWrite  output  1  memory write request.
luiSignal  output  1  lui path select.
alu_select  output  3  ALU operation select.
mem_size  output  2  access size: 00 byte, 01 half, 10 word.
mem_unsigned  output  1  zero-extend the load (lbu/lhu).
state  output  3  current state: IDLE=0, DECODE=1, EXEC=2, MEM=3, WB=4.
illegal_op  output  1  one-cycle pulse for an unsupported opcode.
mem_timeout  output  1  one-cycle pulse when the memory wait expires.
retired  output  CNT_W  count of completed instructions.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, instr_ready=1.
  - All other outputs 0; retired=0; wait counter=0; latched opcode=0.
- IDLE:
  - instr_ready=1.
  - When instr_valid=1, latch opcode and go to DECODE.
- Non-IDLE states:
  - instr_ready=0; instr_valid is ignored.
- DECODE, legal opcodes:
  - Loads: lb 100000, lh 100001, lw 100011, lbu 100100, lhu 100101.
  - Stores: sb 101000, sh 101001, sw 101011.
  - ALU-immediate: 001000..001110.
  - lui: 001111.
  - Legal opcode: go to EXEC.
  - Any other opcode: pulse illegal_op for one cycle, return to IDLE, retired unchanged.
- EXEC:
  - alu_select is decoded from the latched opcode:
    - bit2 = op[1] | op[3]
    - bit1 = (~op[1] & op[0]) | (op[3] & op[0])
    - bit0 = op[2] | (op[3] & ~op[0]) | (op[3] & op[1])
  - alu_select holds this value in EXEC, MEM and WB, and is 0 in IDLE/DECODE.
  - luiSignal=1 in EXEC and WB for lui.
  - Loads and stores go to MEM; ALU-immediate and lui go to WB.
- MEM:
  - MemRead (loads) or MemWrite (stores) is held high every MEM cycle.
  - mem_size and mem_unsigned are valid whenever MemRead or MemWrite is high:
    - lb/lbu/sb: 00
    - lh/lhu/sh: 01
    - lw/sw: 10
  - mem_ready=1: a load goes to WB; a store increments retired and goes to IDLE.
  - mem_ready=0: the wait counter increments.
  - If mem_ready=0 and the counter equals MEM_TIMEOUT-1 (MEM_TIMEOUT>0): pulse mem_timeout, go to IDLE, no retire.
  - mem_ready takes priority over timeout in the same cycle.
  - The wait counter clears on MEM exit.
- WB:
  - RegWrite=1 for exactly one cycle.
  - retired increments; go to IDLE.
- Latency, from the accept edge:
  - ALU-immediate/lui: RegWrite asserted in the 3rd cycle after accept; instr_ready back in the 4th.
  - Load with immediate mem_ready: RegWrite in the 4th cycle after accept.
  - Store with immediate mem_ready: instr_ready back in the 4th cycle.
- abort:
  - From any state, the next state is IDLE.
  - Abort wins over mem_ready, timeout and WB.
  - No retire and no pulses that cycle; MemRead/MemWrite/RegWrite are combinationally forced 0 while abort=1.
- Counters:
  - retired wraps from 2^CNT_W-1 to 0.
  - The wait counter width is clog2(MEM_TIMEOUT+1), minimum 1.
- Glitch-free requirement: every output is registered state or decoded from registered state and the latched opcode. The exception is abort gating.

Test Plan:
1. Reset mid-MEM (lw, mem_ready=0 for 3 cycles, then rst_n=0) -> all outputs 0 immediately; state=0, instr_ready=1, retired=0.
2. ori 001101 accepted -> state 1,2,4,0; alu_select=3'b111 in EXEC/WB; RegWrite high exactly 1 cycle; retired=1.
3. lhu 100101, mem_ready high after 2 wait cycles -> MemRead high 3 cycles, mem_size=01, mem_unsigned=1; RegWrite 1 cycle later; retired increments.
4. sw 101011, MEM_TIMEOUT=4, mem_ready never -> MemWrite high 4 cycles; mem_timeout pulse on the 4th; IDLE; retired unchanged. Repeat with mem_ready on the 4th cycle -> no timeout, retired+1.
5. opcode 000010 -> illegal_op one-cycle pulse in DECODE; back in IDLE; no RegWrite/MemRead/MemWrite.
6. CNT_W=2, five lui instructions back-to-back, with instr_valid held high during busy -> retired 1,2,3,0,1; instr_valid ignored while busy. Separately, abort asserted in WB -> no RegWrite, state 0 next cycle.
